// File: rtl/ibex_trace_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_trace_ctrl
//
// Captures retired-instruction records (RVFI) into a small first-word-fall-
// through FIFO and streams them out over a valid/ready interface.
//
// A capture session:
//   * A 0->1 edge on cfg_en_i arms the block (IDLE -> ARMED). The trigger and
//     stop configuration are latched at that moment.
//   * The first retirement that matches the trigger starts capture and is
//     itself captured (ARMED -> CAPTURE).
//   * Capture ends when the stop count is reached (nonzero stop count) or
//     when cfg_en_i drops. The FIFO then drains, and done_o pulses for the
//     single cycle in which the block returns to IDLE.
//   * Pushes into a full FIFO are dropped and counted. The next entry that
//     is accepted carries out_lost_o=1.
//
// Optional feature: define IBEX_TRACE_CTRL_TSTAMP_EN to add tstamp_i /
// out_tstamp_o. Each entry then also stores tstamp_i as sampled alongside
// rvfi_valid_i.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg_en_i                 capture enable (rising edge arms, low stops)
//   cfg_trig_any_i           1: trigger on any retirement, 0: on PC match
//   cfg_trig_pc_i            trigger PC
//   cfg_stop_cnt_i           retirements to capture, 0 = unlimited
//   rvfi_valid_i/trap_i      retirement strobe and trap flag
//   rvfi_pc_rdata_i/insn_i   retired PC and instruction
//   out_valid_o/out_ready_i  trace stream handshake
//   out_pc_o/insn_o/trap_o   head entry of the FIFO
//   out_lost_o               entry follows one or more dropped retirements
//   state_o                  FSM state (IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3)
//   overflow_cnt_o           dropped retirements (saturating)
//   done_o                   one-cycle end-of-session pulse
//
// Handshake: an entry transfers on every rising clk_i edge where
// out_valid_o && out_ready_i. While out_valid_o=1 and out_ready_i=0 the
// out_* data outputs hold their value. out_valid_o never depends on
// out_ready_i.
// ----------------------------------------------------------------------------
module ibex_trace_ctrl #(
    parameter int unsigned Depth = 8,
    parameter int unsigned CntW  = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_en_i,
    input  logic            cfg_trig_any_i,
    input  logic [31:0]     cfg_trig_pc_i,
    input  logic [CntW-1:0] cfg_stop_cnt_i,
    input  logic            rvfi_valid_i,
    input  logic            rvfi_trap_i,
    input  logic [31:0]     rvfi_pc_rdata_i,
    input  logic [31:0]     rvfi_insn_i,
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
    input  logic [15:0]     tstamp_i,
    output logic [15:0]     out_tstamp_o,
`endif
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_pc_o,
    output logic [31:0]     out_insn_o,
    output logic            out_trap_o,
    output logic            out_lost_o,
    output logic [1:0]      state_o,
    output logic [CntW-1:0] overflow_cnt_o,
    output logic            done_o
);

    localparam int unsigned AW = $clog2(Depth);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_en_q;
    logic            r_trig_any;
    logic [31:0]     r_trig_pc;
    logic [CntW-1:0] r_stop_cnt;
    logic [CntW-1:0] r_cap_cnt;
    logic [CntW-1:0] w_cap_cnt_nxt;
    logic [CntW-1:0] w_cap_inc;
    logic [CntW-1:0] r_ovf_cnt;
    logic            r_lost_pend;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [31:0]     r_mem_pc   [Depth];
    logic [31:0]     r_mem_insn [Depth];
    logic            r_mem_trap [Depth];
    logic            r_mem_lost [Depth];
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
    logic [15:0]     r_mem_ts   [Depth];
`endif

    logic w_arm;
    logic w_push_req;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_done;
    logic w_trig_hit;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_cap_inc  = (r_cap_cnt == {CntW{1'b1}}) ? r_cap_cnt
                                                    : r_cap_cnt + CntW'(1);
    assign w_trig_hit = r_trig_any || (rvfi_pc_rdata_i == r_trig_pc);

    // A full FIFO drops the push even if a pop happens in the same cycle.
    assign w_push = w_push_req && !w_full;
    assign w_drop = w_push_req &&  w_full;
    assign w_pop  = out_valid_o && out_ready_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_cap_cnt_nxt = r_cap_cnt;
        w_arm         = 1'b0;
        w_push_req    = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_en_i && !r_en_q) begin
                    w_state_nxt   = ST_ARMED;
                    w_arm         = 1'b1;
                    w_cap_cnt_nxt = '0;
                end
            end
            ST_ARMED: begin
                if (!cfg_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (rvfi_valid_i && w_trig_hit) begin
                    // The trigger retirement is the first captured one.
                    w_push_req    = 1'b1;
                    w_cap_cnt_nxt = CntW'(1);
                    if (r_stop_cnt == CntW'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (rvfi_valid_i) begin
                    w_push_req    = 1'b1;
                    w_cap_cnt_nxt = w_cap_inc;
                end
                if (!cfg_en_i ||
                    (rvfi_valid_i && (r_stop_cnt != '0) && (w_cap_inc == r_stop_cnt))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_en_q      <= 1'b0;
            r_trig_any  <= 1'b0;
            r_trig_pc   <= '0;
            r_stop_cnt  <= '0;
            r_cap_cnt   <= '0;
            r_ovf_cnt   <= '0;
            r_lost_pend <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_en_q    <= cfg_en_i;
            r_cap_cnt <= w_cap_cnt_nxt;
            if (w_arm) begin
                r_trig_any <= cfg_trig_any_i;
                r_trig_pc  <= cfg_trig_pc_i;
                r_stop_cnt <= cfg_stop_cnt_i;
                r_ovf_cnt  <= '0;
            end else if (w_drop && (r_ovf_cnt != {CntW{1'b1}})) begin
                r_ovf_cnt <= r_ovf_cnt + CntW'(1);
            end
            if (w_drop) begin
                r_lost_pend <= 1'b1;
            end else if (w_push) begin
                r_lost_pend <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: entries are only visible when out_valid_o=1.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_pc[r_wptr[AW-1:0]]   <= rvfi_pc_rdata_i;
            r_mem_insn[r_wptr[AW-1:0]] <= rvfi_insn_i;
            r_mem_trap[r_wptr[AW-1:0]] <= rvfi_trap_i;
            r_mem_lost[r_wptr[AW-1:0]] <= r_lost_pend;
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
            r_mem_ts[r_wptr[AW-1:0]]   <= tstamp_i;
`endif
        end
    end

    assign out_valid_o    = !w_empty;
    assign out_pc_o       = out_valid_o ? r_mem_pc[r_rptr[AW-1:0]]   : '0;
    assign out_insn_o     = out_valid_o ? r_mem_insn[r_rptr[AW-1:0]] : '0;
    assign out_trap_o     = out_valid_o && r_mem_trap[r_rptr[AW-1:0]];
    assign out_lost_o     = out_valid_o && r_mem_lost[r_rptr[AW-1:0]];
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
    assign out_tstamp_o   = out_valid_o ? r_mem_ts[r_rptr[AW-1:0]] : '0;
`endif
    assign state_o        = r_state;
    assign overflow_cnt_o = r_ovf_cnt;
    assign done_o         = w_done;

endmodule

// File: tb/tb_ibex_trace_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ibex_trace_ctrl
//
// Self-checking bench for ibex_trace_ctrl (Depth=8, CntW=16).
// Sections: clock/reset, driver tasks, a pop monitor feeding got_q,
// a table of capture scenarios, hand-written corner sequences, randomized
// sessions checked against a queue-based session model, final report.
// ----------------------------------------------------------------------------
module tb_ibex_trace_ctrl;

    localparam int Depth = 8;
    localparam int CntW  = 16;

    logic            clk;
    logic            rst_n;
    logic            cfg_en;
    logic            cfg_trig_any;
    logic [31:0]     cfg_trig_pc;
    logic [CntW-1:0] cfg_stop_cnt;
    logic            rvfi_valid;
    logic            rvfi_trap;
    logic [31:0]     rvfi_pc;
    logic [31:0]     rvfi_insn;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_insn;
    logic            out_trap;
    logic            out_lost;
    logic [1:0]      state;
    logic [CntW-1:0] ovf_cnt;
    logic            done;
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
    logic [15:0]     tstamp;
    logic [15:0]     out_tstamp;
`endif

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Entry layout: {pc[31:0], insn[31:0], trap, lost}
    logic [65:0] got_q[$];
    logic [65:0] exp_q[$];

    ibex_trace_ctrl #(
        .Depth(Depth),
        .CntW (CntW)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_en_i       (cfg_en),
        .cfg_trig_any_i (cfg_trig_any),
        .cfg_trig_pc_i  (cfg_trig_pc),
        .cfg_stop_cnt_i (cfg_stop_cnt),
        .rvfi_valid_i   (rvfi_valid),
        .rvfi_trap_i    (rvfi_trap),
        .rvfi_pc_rdata_i(rvfi_pc),
        .rvfi_insn_i    (rvfi_insn),
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
        .tstamp_i       (tstamp),
        .out_tstamp_o   (out_tstamp),
`endif
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_pc_o       (out_pc),
        .out_insn_o     (out_insn),
        .out_trap_o     (out_trap),
        .out_lost_o     (out_lost),
        .state_o        (state),
        .overflow_cnt_o (ovf_cnt),
        .done_o         (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor (negedge, away from the active edge) ----------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_pc, out_insn, out_trap, out_lost});
        end
        if (rst_n && done) begin
            done_cnt++;
        end
    end

    // ---------------- helpers / drivers ----------------
    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [65:0] ent(input logic [31:0] pc, input logic lost);
        return {pc, insn_of(pc), pc[2], lost};
    endfunction

    function automatic logic [65:0] q_at(input int idx);
        if (idx >= 0 && idx < got_q.size()) return got_q[idx];
        return '0;
    endfunction

    task automatic drive_ret(input logic v, input logic [31:0] pc);
        rvfi_valid = v;
        rvfi_pc    = pc;
        rvfi_insn  = insn_of(pc);
        rvfi_trap  = pc[2];
    endtask

    task automatic arm(input logic any, input logic [31:0] tpc, input int stop);
        cfg_en = 1'b0;
        step();
        cfg_trig_any = any;
        cfg_trig_pc  = tpc;
        cfg_stop_cnt = CntW'(stop);
        cfg_en       = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (state !== 2'd0 && k < max) begin
            step();
            k++;
        end
        check(name, {64'd0, state}, 66'd0);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic        trig_any;
        logic [31:0] trig_pc;
        int          stop;
        logic [31:0] base;
        int          n_ret;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    // random-session storage
    logic        r_v     [32];
    logic        r_rdy   [32];
    logic [31:0] r_pc    [32];
    logic [31:0] r_insn  [32];
    logic        r_trap  [32];
    logic        model_lost;

    initial begin
        int d0;
        vecs[0] = '{1'b1, 32'h0,   3, 32'h100, 5, 3, 32'h100, 32'h108, 1};
        vecs[1] = '{1'b0, 32'h200, 2, 32'h1F8, 4, 2, 32'h200, 32'h204, 1};
        vecs[2] = '{1'b1, 32'h0,   1, 32'h400, 3, 1, 32'h400, 32'h400, 1};
        vecs[3] = '{1'b0, 32'h900, 2, 32'h300, 4, 0, 32'h0,   32'h0,   0};
        vecs[4] = '{1'b1, 32'h0,   0, 32'h500, 6, 6, 32'h500, 32'h514, 1};
        vecs[5] = '{1'b0, 32'h60C, 0, 32'h600, 5, 2, 32'h60C, 32'h610, 1};

        // ---------------- reset ----------------
        rst_n        = 1'b0;
        cfg_en       = 1'b0;
        cfg_trig_any = 1'b0;
        cfg_trig_pc  = '0;
        cfg_stop_cnt = '0;
        out_ready    = 1'b0;
        drive_ret(1'b0, 32'h0);
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
        tstamp = '0;
`endif
        model_lost = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {64'd0, state}, 66'd0);
        check("rst_valid", {65'd0, out_valid}, 66'd0);
        check("rst_done", {65'd0, done}, 66'd0);
        check("rst_ovf", {50'd0, ovf_cnt}, 66'd0);
        check("rst_out", {out_pc, out_insn, out_trap, out_lost}, 66'd0);
        rst_n = 1'b1;
        step();

        // ---------------- table-driven scenarios ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            arm(vecs[i].trig_any, vecs[i].trig_pc, vecs[i].stop);
            check($sformatf("v%0d_armed", i), {64'd0, state}, 66'd1);
            got_q.delete();
            d0 = done_cnt;
            for (int k = 0; k < vecs[i].n_ret; k++) begin
                drive_ret(1'b1, vecs[i].base + 32'(4 * k));
                step();
            end
            drive_ret(1'b0, 32'h0);
            cfg_en = 1'b0;
            wait_idle($sformatf("v%0d_idle", i), 40);
            check($sformatf("v%0d_count", i), 66'(got_q.size()), 66'(vecs[i].exp_n));
            check($sformatf("v%0d_first", i), {34'd0, q_at(0)[65:34]}, {34'd0, vecs[i].exp_first});
            check($sformatf("v%0d_last", i), {34'd0, q_at(got_q.size() - 1)[65:34]},
                  {34'd0, vecs[i].exp_last});
            check($sformatf("v%0d_done", i), 66'(done_cnt - d0), 66'(vecs[i].exp_done));
            check($sformatf("v%0d_ovf", i), {50'd0, ovf_cnt}, 66'd0);
        end

        // ---------------- overflow and lost flag ----------------
        out_ready = 1'b0;
        arm(1'b1, 32'h0, 0);
        got_q.delete();
        for (int k = 0; k < 12; k++) begin
            drive_ret(1'b1, 32'h2000 + 32'(4 * k));
            step();
        end
        drive_ret(1'b0, 32'h0);
        check("ovf_cnt", {50'd0, ovf_cnt}, 66'd4);
        check("ovf_valid", {65'd0, out_valid}, 66'd1);
        check("ovf_head", {out_pc, out_insn, out_trap, out_lost}, ent(32'h2000, 1'b0));
        step();
        step();
        check("hold_stable", {out_pc, out_insn, out_trap, out_lost}, ent(32'h2000, 1'b0));
        check("ovf_state", {64'd0, state}, 66'd2);
        out_ready = 1'b1;
        repeat (10) step();
        check("ovf_popped", 66'(got_q.size()), 66'd8);
        check("ovf_first", q_at(0), ent(32'h2000, 1'b0));
        check("ovf_eighth", q_at(7), ent(32'h201C, 1'b0));
        drive_ret(1'b1, 32'h3000);
        step();
        drive_ret(1'b0, 32'h0);
        check("lost_set", {out_pc, out_insn, out_trap, out_lost}, ent(32'h3000, 1'b1));
        step();
        drive_ret(1'b1, 32'h3004);
        step();
        drive_ret(1'b0, 32'h0);
        check("lost_clear", {out_pc, out_insn, out_trap, out_lost}, ent(32'h3004, 1'b0));
        cfg_en = 1'b0;
        wait_idle("ovf_idle", 40);

        // ---------------- enable held high does not re-arm ----------------
        arm(1'b1, 32'h0, 2);
        check("ovf_clear_on_arm", {50'd0, ovf_cnt}, 66'd0);
        d0 = done_cnt;
        drive_ret(1'b1, 32'h5000);
        step();
        drive_ret(1'b1, 32'h5004);
        step();
        drive_ret(1'b0, 32'h0);
        wait_idle("held_idle", 40);
        repeat (5) step();
        check("held_no_rearm", {64'd0, state}, 66'd0);
        check("held_done_once", 66'(done_cnt - d0), 66'd1);
        cfg_en = 1'b0;
        step();
        cfg_en = 1'b1;
        step();
        check("rearm_state", {64'd0, state}, 66'd1);
        check("rearm_ovf", {50'd0, ovf_cnt}, 66'd0);
        cfg_en = 1'b0;
        step();
        check("armed_abort", {64'd0, state}, 66'd0);

        // ---------------- disable in same cycle as a retirement ----------------
        arm(1'b1, 32'h0, 0);
        got_q.delete();
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
        tstamp = 16'h0010;
`endif
        drive_ret(1'b1, 32'h4000);
        step();
`ifdef IBEX_TRACE_CTRL_TSTAMP_EN
        tstamp = 16'h0077;
        check("tstamp", {50'd0, out_tstamp}, 66'h10);
`endif
        drive_ret(1'b1, 32'h4004);
        step();
        drive_ret(1'b1, 32'h4008);
        cfg_en = 1'b0;
        step();
        drive_ret(1'b0, 32'h0);
        wait_idle("dis_idle", 40);
        check("dis_count", 66'(got_q.size()), 66'd3);
        check("dis_last", q_at(2), ent(32'h4008, 1'b0));

        // ---------------- reset mid-capture ----------------
        out_ready = 1'b0;
        arm(1'b1, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            drive_ret(1'b1, 32'h7000 + 32'(4 * k));
            step();
        end
        drive_ret(1'b0, 32'h0);
        check("pre_rst_valid", {65'd0, out_valid}, 66'd1);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {65'd0, out_valid}, 66'd0);
        check("mid_rst_state", {64'd0, state}, 66'd0);
        check("mid_rst_done", {65'd0, done}, 66'd0);
        cfg_en = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check("post_rst_no_done", 66'(done_cnt - d0), 66'd0);
        check("post_rst_valid", {65'd0, out_valid}, 66'd0);
        model_lost = 1'b0;

        // ---------------- randomized sessions vs. session model ----------------
        for (int s = 0; s < 30; s++) begin
            int          n_cyc;
            int          stop;
            logic        any;
            logic [31:0] tpc;
            logic [31:0] next_pc;
            logic        trig_seen;
            int          cap_n;
            int          occ;
            int          drops;
            logic        pop;
            logic        push;

            n_cyc   = $urandom_range(8, 24);
            stop    = $urandom_range(0, 4);
            any     = 1'($urandom_range(0, 1));
            tpc     = 32'h1000 + 32'(4 * $urandom_range(0, 12));
            next_pc = 32'h1000;
            for (int c = 0; c < n_cyc; c++) begin
                r_v[c]    = ($urandom_range(0, 9) < 7);
                r_rdy[c]  = ($urandom_range(0, 9) < 4);
                r_insn[c] = $urandom;
                r_trap[c] = 1'($urandom_range(0, 1));
                if (r_v[c]) begin
                    r_pc[c] = next_pc;
                    next_pc = next_pc + 32'd4;
                end else begin
                    r_pc[c] = $urandom;
                end
            end

            // Model: trigger is the first matching retirement; it and the
            // following ones are captured until stop count (0 = all).
            // Occupancy decides which captured retirements are dropped.
            exp_q.delete();
            trig_seen = 1'b0;
            cap_n     = 0;
            occ       = 0;
            drops     = 0;
            for (int c = 0; c < n_cyc; c++) begin
                pop  = (occ > 0) && r_rdy[c];
                push = 1'b0;
                if (r_v[c] && !trig_seen && (any || r_pc[c] == tpc)) trig_seen = 1'b1;
                if (r_v[c] && trig_seen && (stop == 0 || cap_n < stop)) begin
                    push  = 1'b1;
                    cap_n = cap_n + 1;
                end
                if (push) begin
                    if (occ == Depth) begin
                        drops      = drops + 1;
                        model_lost = 1'b1;
                    end else begin
                        exp_q.push_back({r_pc[c], r_insn[c], r_trap[c], model_lost});
                        model_lost = 1'b0;
                        occ        = occ + 1;
                    end
                end
                if (pop) occ = occ - 1;
            end

            arm(any, tpc, stop);
            got_q.delete();
            d0 = done_cnt;
            // Config changes after arming must not matter.
            cfg_trig_any = 1'($urandom_range(0, 1));
            cfg_trig_pc  = 32'h1000 + 32'(4 * $urandom_range(0, 12));
            cfg_stop_cnt = CntW'($urandom_range(0, 4));
            for (int c = 0; c < n_cyc; c++) begin
                rvfi_valid = r_v[c];
                rvfi_pc    = r_pc[c];
                rvfi_insn  = r_insn[c];
                rvfi_trap  = r_trap[c];
                out_ready  = r_rdy[c];
                step();
            end
            drive_ret(1'b0, 32'h0);
            out_ready = 1'b1;
            check($sformatf("rnd%0d_ovf", s), {50'd0, ovf_cnt}, 66'(drops));
            cfg_en = 1'b0;
            wait_idle($sformatf("rnd%0d_idle", s), 60);
            check($sformatf("rnd%0d_count", s), 66'(got_q.size()), 66'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("rnd%0d_e%0d", s, i), q_at(i), exp_q[i]);
            end
            check($sformatf("rnd%0d_done", s), 66'(done_cnt - d0), {65'd0, trig_seen});
        end

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
